// File: rtl/fetch_stage.sv
// Purpose : instruction-fetch stage. Holds the PC, drives the instruction
//           memory address, captures the returned word into the fetch/decode
//           register and applies branch redirects (early ones are held).
// Latency : imem_addr follows pc combinationally. All other outputs are
//           registered and update on the clk edge that samples the strobe.
// Backpressure: none. The core sequencer paces the stage with pc_wren and
//           fd_wren, and the stage never stalls it.
//
// Ports:
//   clk, reset_n          core clock; synchronous active-low reset
//   pc_wren               advance or redirect the PC this cycle
//   fd_wren               capture imem_rdata/pc into ir/ir_pc
//   branch_en,
//   branch_target         redirect request (applied now or held until pc_wren)
//   imem_addr, imem_rdata synchronous instruction RAM (1-cycle read latency)
//   pc, ir, ir_pc         program counter and fetch/decode register
//   ir_valid              ir holds a word fetched since reset or the last redirect
//   fetch_count           number of fd_wren captures (wraps at 2^32)
//   fetch_fault           sticky misaligned-branch-target flag
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   -> a branch_target with nonzero bits [1:0] sets fetch_fault
//   undefined -> fetch_fault is tied low and no detection logic is built

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_wren,
  input  logic        fd_wren,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  localparam logic [31:0] PC_INC    = 32'(PC_STEP);
  // Instructions are word aligned, so redirect targets drop their low two bits.
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // Redirect that arrived while pc_wren was low, held until the next PC update.
  logic        br_pending;
  logic [31:0] br_target;

  logic [31:0] target_aligned;
  logic        redirect;
  logic [31:0] pc_next;

  assign target_aligned = branch_target & WORD_MASK;

  // The memory address is the PC itself; the RAM registers it internally.
  assign imem_addr = pc;

  // PC selection. A same-cycle branch beats a held one, and either beats the
  // sequential step. redirect only has an effect when pc_wren is high.
  always_comb begin
    redirect = 1'b0;
    pc_next  = pc + PC_INC;
    if (branch_en) begin
      redirect = 1'b1;
      pc_next  = target_aligned;
    end else if (br_pending) begin
      redirect = 1'b1;
      pc_next  = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      ir          <= 32'h0;
      ir_pc       <= 32'h0;
      ir_valid    <= 1'b0;
      fetch_count <= 32'h0;
      br_pending  <= 1'b0;
      br_target   <= 32'h0;
    end else begin
      // PC update, or park an early redirect until the sequencer moves the PC.
      if (pc_wren) begin
        pc <= pc_next;
        if (redirect) begin
          br_pending <= 1'b0;
        end
      end else if (branch_en) begin
        // Last request wins if several arrive before pc_wren.
        br_target  <= target_aligned;
        br_pending <= 1'b1;
      end

      // Capture uses the pre-update pc, so a same-cycle pc_wren does not
      // disturb ir_pc. A capture in the same cycle as a redirect keeps
      // ir_valid set: the sequencer has declared that word good.
      if (fd_wren) begin
        ir          <= imem_rdata;
        ir_pc       <= pc;
        ir_valid    <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end else if (pc_wren && redirect) begin
        ir_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Flag any misaligned request, held or applied directly; sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_fault <= 1'b0;
    end else if (branch_en && (branch_target[1:0] != 2'b00)) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_wren;
  logic        fd_wren;
  logic        branch_en;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic [31:0] fetch_count;
  logic        fetch_fault;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  fetch_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_wren       (pc_wren),
    .fd_wren       (fd_wren),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .fetch_count   (fetch_count),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: architectural state, with held redirects kept in a queue
  // that holds at most one entry (the latest request).
  logic [31:0] m_pc, m_ir, m_ir_pc, m_cnt;
  logic        m_valid, m_fault;
  logic [31:0] pend_q[$];

  task automatic model_reset();
    m_pc    = 32'h0;
    m_ir    = 32'h0;
    m_ir_pc = 32'h0;
    m_valid = 1'b0;
    m_cnt   = 32'h0;
    m_fault = 1'b0;
    pend_q.delete();
  endtask

  task automatic model_step();
    logic [31:0] old_pc;
    logic [31:0] tgt;
    bit          redirected;
    if (!reset_n) begin
      model_reset();
    end else begin
      old_pc     = m_pc;
      tgt        = branch_target - (branch_target % 4);
      redirected = 1'b0;
      if (ALIGN_CHECK && branch_en && (branch_target % 4 != 0)) m_fault = 1'b1;
      if (fd_wren) begin
        m_ir    = imem_rdata;
        m_ir_pc = old_pc;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 1;
      end
      if (pc_wren) begin
        if (branch_en) begin
          m_pc = tgt;
          redirected = 1'b1;
          pend_q.delete();
        end else if (pend_q.size() > 0) begin
          m_pc = pend_q.pop_front();
          redirected = 1'b1;
        end else begin
          m_pc = old_pc + 4;
        end
        if (redirected && !fd_wren) m_valid = 1'b0;
      end else if (branch_en) begin
        pend_q.delete();
        pend_q.push_back(tgt);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},          pc,                  m_pc);
    check({tag, ".imem_addr"},   imem_addr,           m_pc);
    check({tag, ".ir"},          ir,                  m_ir);
    check({tag, ".ir_pc"},       ir_pc,               m_ir_pc);
    check({tag, ".ir_valid"},    {31'h0, ir_valid},   {31'h0, m_valid});
    check({tag, ".fetch_count"}, fetch_count,         m_cnt);
    check({tag, ".fetch_fault"}, {31'h0, fetch_fault}, {31'h0, m_fault});
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic rst_n, input logic pcw, input logic fdw,
                       input logic br, input logic [31:0] tgt, input logic [31:0] rdata);
    reset_n       = rst_n;
    pc_wren       = pcw;
    fd_wren       = fdw;
    branch_en     = br;
    branch_target = tgt;
    imem_rdata    = rdata;
  endtask

  initial begin
    logic [31:0] words [3];
    words[0] = 32'h11;
    words[1] = 32'h22;
    words[2] = 32'h33;
    model_reset();

    // Reset state.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("reset");
    tick("reset2");
    check("reset_pc", pc, 32'h0);

    // Three fetch rounds: capture, then advance.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, words[i]);
      tick("fetch_cap");
      check("fetch_ir", ir, words[i]);
      check("fetch_ir_pc", ir_pc, 32'(4 * i));
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
      tick("fetch_adv");
    end
    check("round_pc", pc, 32'd12);
    check("round_count", fetch_count, 32'd3);
    check("round_valid", {31'h0, ir_valid}, 32'd1);

    // Early redirects, last one wins, applied on the next pc_wren.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
    tick("early1");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
    tick("early2");
    check("early_hold_pc", pc, 32'd12);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("early_apply");
    check("early_pc", pc, 32'h200);
    check("early_valid", {31'h0, ir_valid}, 32'd0);
    tick("early_next");
    check("early_next_pc", pc, 32'h204);

    // PC wrap at the top of the address space.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    tick("to_top");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("pc_wrap");
    check("pc_wrap", pc, 32'h0);

    // Capture counter wrap, preloaded near its limit.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    m_cnt = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h5555);
    tick("cnt_wrap");
    check("cnt_wrap", fetch_count, 32'h0);

    // Capture and advance in the same cycle, then capture alongside a branch.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    tick("to_40");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'hABCD);
    tick("dual");
    check("dual_ir_pc", ir_pc, 32'h40);
    check("dual_ir", ir, 32'hABCD);
    check("dual_pc", pc, 32'h44);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h1234);
    tick("dual_br");
    check("dual_br_pc", pc, 32'h80);
    check("dual_br_valid", {31'h0, ir_valid}, 32'd1);
    check("dual_br_ir_pc", ir_pc, 32'h44);

    // Reset discards a held redirect.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h0);
    tick("pend_300");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("pend_reset");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("post_reset");
    check("post_reset_pc", pc, 32'h4);

    // Misaligned target: low bits dropped, fault only with the check built.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h102, 32'h0);
    tick("misalign");
    check("misalign_fault", {31'h0, fetch_fault}, {31'h0, ALIGN_CHECK});
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("misalign_apply");
    check("misalign_pc", pc, 32'h100);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick("misalign_hold");
    check("misalign_hold", {31'h0, fetch_fault}, {31'h0, ALIGN_CHECK});

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) == 0),
            t, $urandom);
      tick("rand");
    end

    // Final reset clears everything, including a sticky fault.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h7, 32'h99);
    tick("final_reset");
    check("final_fault", {31'h0, fetch_fault}, 32'd0);
    check("final_pc", pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
